// File: rtl/seq_det_param.sv
// Parametrised serial bit-pattern detector with reloadable pattern, optional
// overlap, input qualifier and a saturating match counter.
module seq_det_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               B,
  input  logic               Pat_Ld,
  input  logic [PAT_LEN-1:0] Pat_In,
  input  logic               Cnt_Clr,
  output logic               w,
  output logic [CNT_W-1:0]   Match_Cnt,
  output logic [PAT_LEN-1:0] Pat_Cur
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;

  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  // fill guards against a zero-filled history matching an all-zero pattern
  always_comb begin
    hist_n = {hist[PAT_LEN-2:0], B};
    fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
    match  = En && !Pat_Ld && (hist_n == pat) && (fill_n == FILL_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pat       <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      w         <= 1'b0;
      Match_Cnt <= '0;
    end else begin
      if (Pat_Ld) begin
        pat  <= Pat_In;
        hist <= '0;
        fill <= '0;
        w    <= 1'b0;
      end else if (En) begin
        hist <= hist_n;
        fill <= (match && (OVERLAP == 0)) ? '0 : fill_n;
        w    <= match;
      end else begin
        w <= 1'b0;
      end

      // a clear coinciding with a match still counts that match
      if (match) begin
        if (Cnt_Clr)
          Match_Cnt <= CNT_W'(1);
        else if (Match_Cnt != CNT_MAX)
          Match_Cnt <= Match_Cnt + 1'b1;
      end else if (Cnt_Clr) begin
        Match_Cnt <= '0;
      end
    end
  end

  assign Pat_Cur = pat;

endmodule
